// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit with memory-mapped I/O:
//   - FSM state enum and address-region enum
//   - RV32 load/store funct3 width codes
//   - MMIO base addresses for the LED, HEX, LCD, switch and button blocks
//   - helpers for byte enables, store lane replication and load extraction
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RG_NONE,
        RG_DMEM,
        RG_LEDR,
        RG_LEDG,
        RG_HEX,
        RG_LCD,
        RG_SW,
        RG_BTN
    } region_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LEDR_BASE = 32'h0000_7000;
    localparam logic [31:0] LEDG_BASE = 32'h0000_7010;
    localparam logic [31:0] HEX_BASE  = 32'h0000_7020;
    localparam logic [31:0] LCD_BASE  = 32'h0000_7030;
    localparam logic [31:0] SW_BASE   = 32'h0000_7800;
    localparam logic [31:0] BTN_BASE  = 32'h0000_7810;

    // Byte lanes touched by a store; only meaningful for legal store widths.
    function automatic logic [3:0] byteEnable(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across the word so every enabled lane
    // already carries the right byte without a shifter.
    function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Pick the addressed byte/half out of a word and sign/zero extend it.
    function automatic logic [31:0] loadExtract(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'b0, s[7:0]};
            F3_HU:   return {16'b0, s[15:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// ---------------------------------------------------------------------------
// lsu_dmem
// Single-port data memory, WORDS x 32 bit, four byte write enables and a
// registered (synchronous) read. Contents are deliberately not reset.
//   i_clk    : clock, rising edge
//   i_en     : read enable, captures mem[i_addr] into o_rdata
//   i_we     : per-byte write enables
//   i_addr   : word index
//   i_wdata  : write data, byte j taken from [8j+7:8j]
//   o_rdata  : registered read data
// ---------------------------------------------------------------------------
module lsu_dmem #(
    parameter int WORDS = 2048,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    // Byte-granular write; read returns the pre-write contents.
    always_ff @(posedge i_clk) begin
        for (int j = 0; j < 4; j++) begin
            if (i_we[j]) begin
                mem[i_addr][8*j +: 8] <= i_wdata[8*j +: 8];
            end
        end
        if (i_en) begin
            rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/lsu_mmio.sv
// ---------------------------------------------------------------------------
// lsu_mmio
// Load/store unit with data memory and memory-mapped board I/O. Each accepted
// request walks IDLE -> ACCESS -> RESP and answers with a one-cycle strobe.
//   i_clk, i_rst            : clock and asynchronous active-high reset
//   i_req / o_ready         : request handshake (accept when both high)
//   i_wren, i_funct3        : store/load select and RV32 width code
//   i_lsu_addr, i_st_data   : byte address and store data
//   o_rsp_valid             : response strobe, with o_ld_data and o_fault
//   i_io_sw, i_io_btn       : switch and button inputs
//   o_io_ledr, o_io_ledg    : red and green LEDs
//   o_io_hex                : 7-segment digits, digit k at [7k+6:7k]
//   o_io_lcd                : LCD word register
// ---------------------------------------------------------------------------
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int          DMEM_WORDS = 2048,
    parameter logic [31:0] DMEM_BASE  = 32'h2000,
    parameter int          N_HEX      = 8,
    parameter int          LEDR_W     = 17,
    parameter int          LEDG_W     = 8,
    parameter int          SW_W       = 18,
    parameter int          BTN_W      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    output logic               o_ready,
    input  logic               i_wren,
    input  logic [2:0]         i_funct3,
    input  logic [31:0]        i_lsu_addr,
    input  logic [31:0]        i_st_data,
    output logic               o_rsp_valid,
    output logic [31:0]        o_ld_data,
    output logic               o_fault,
    input  logic [SW_W-1:0]    i_io_sw,
    input  logic [BTN_W-1:0]   i_io_btn,
    output logic [LEDR_W-1:0]  o_io_ledr,
    output logic [LEDG_W-1:0]  o_io_ledg,
    output logic [7*N_HEX-1:0] o_io_hex,
    output logic [31:0]        o_io_lcd
);

    localparam int          AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
    localparam logic [31:0] HEX_BYTES  = 32'(N_HEX);

    state_e       state_q, state_d;
    logic [31:0]  addr_q, data_q;
    logic [2:0]   f3_q;
    logic         wren_q;

    region_e      region;
    logic [31:0]  dmemOff, hexOff, hexWordBase;
    logic [2:0]   accessSize;
    logic         f3Legal, misaligned, fault, doWrite;
    logic [3:0]   be;
    logic [31:0]  lane;
    logic [31:0]  dmemRdata;

    logic [LEDR_W-1:0] ledr_q;
    logic [LEDG_W-1:0] ledg_q;
    logic [31:0]       lcd_q;
    logic [7:0]        hex_q [N_HEX];

    logic [31:0]  ioWord, ledrWord, ledgWord, swWord, btnWord, hexWord;
    logic [31:0]  ioWord_q;
    logic         fault_q, isDmem_q;

    wire accept = (state_q == ST_IDLE) && i_req;

    // FSM state register; reset drops any in-flight request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: fixed three-cycle walk per accepted request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; response fields are forced to zero outside RESP.
    always_comb begin
        o_ready     = 1'b0;
        o_rsp_valid = 1'b0;
        o_fault     = 1'b0;
        o_ld_data   = '0;
        case (state_q)
            ST_IDLE: o_ready = 1'b1;
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_fault     = fault_q;
                if (!fault_q && !wren_q) begin
                    o_ld_data = loadExtract(isDmem_q ? dmemRdata : ioWord_q,
                                            f3_q, addr_q[1:0]);
                end
            end
            default: ;
        endcase
    end

    // Request capture on accept; held through ACCESS and RESP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= '0;
            data_q <= '0;
            f3_q   <= '0;
            wren_q <= 1'b0;
        end else if (accept) begin
            addr_q <= i_lsu_addr;
            data_q <= i_st_data;
            f3_q   <= i_funct3;
            wren_q <= i_wren;
        end
    end

    // Region decode and fault rules for the captured request. Offsets are
    // computed by subtraction so range checks never overflow at the top.
    always_comb begin
        dmemOff     = addr_q - DMEM_BASE;
        hexOff      = addr_q - HEX_BASE;
        hexWordBase = {hexOff[31:2], 2'b00};

        region = RG_NONE;
        if ((addr_q >= DMEM_BASE) && (dmemOff < DMEM_BYTES))      region = RG_DMEM;
        else if (addr_q[31:4] == LEDR_BASE[31:4])                 region = RG_LEDR;
        else if (addr_q[31:4] == LEDG_BASE[31:4])                 region = RG_LEDG;
        else if ((addr_q >= HEX_BASE) && (hexOff < HEX_BYTES))    region = RG_HEX;
        else if (addr_q[31:4] == LCD_BASE[31:4])                  region = RG_LCD;
        else if (addr_q[31:4] == SW_BASE[31:4])                   region = RG_SW;
        else if (addr_q[31:4] == BTN_BASE[31:4])                  region = RG_BTN;

        case (f3_q[1:0])
            2'b00:   accessSize = 3'd1;
            2'b01:   accessSize = 3'd2;
            default: accessSize = 3'd4;
        endcase

        if (wren_q) f3Legal = (f3_q == F3_B) || (f3_q == F3_H) || (f3_q == F3_W);
        else        f3Legal = (f3_q == F3_B) || (f3_q == F3_H) || (f3_q == F3_W) ||
                              (f3_q == F3_BU) || (f3_q == F3_HU);

        misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));

        fault = (region == RG_NONE) || !f3Legal || misaligned ||
                (wren_q && ((region == RG_SW) || (region == RG_BTN))) ||
                (wren_q && (f3_q != F3_W) &&
                 ((region == RG_LEDR) || (region == RG_LEDG) || (region == RG_LCD))) ||
                ((region == RG_HEX) && ((hexOff + {29'b0, accessSize}) > HEX_BYTES));

        doWrite = (state_q == ST_ACCESS) && wren_q && !fault;
        be      = byteEnable(f3_q, addr_q[1:0]);
        lane    = laneData(f3_q, data_q);
    end

    lsu_dmem #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_en    ((state_q == ST_ACCESS) && (region == RG_DMEM)),
        .i_we    ((doWrite && (region == RG_DMEM)) ? be : 4'b0000),
        .i_addr  (dmemOff[AW+1:2]),
        .i_wdata (lane),
        .o_rdata (dmemRdata)
    );

    // I/O output registers, written on the ACCESS edge of a legal store.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            for (int k = 0; k < N_HEX; k++) hex_q[k] <= '0;
        end else if (doWrite) begin
            case (region)
                RG_LEDR: ledr_q <= data_q[LEDR_W-1:0];
                RG_LEDG: ledg_q <= data_q[LEDG_W-1:0];
                RG_LCD:  lcd_q  <= data_q;
                RG_HEX: begin
                    for (int j = 0; j < 4; j++) begin
                        for (int k = 0; k < N_HEX; k++) begin
                            if (be[j] && ((hexWordBase + 32'(j)) == 32'(k))) begin
                                hex_q[k] <= lane[8*j +: 8];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Word view of the addressed I/O block; HEX bytes past N_HEX read as 0.
    always_comb begin
        ledrWord = '0;
        ledgWord = '0;
        swWord   = '0;
        btnWord  = '0;
        hexWord  = '0;
        ledrWord[LEDR_W-1:0] = ledr_q;
        ledgWord[LEDG_W-1:0] = ledg_q;
        swWord[SW_W-1:0]     = i_io_sw;
        btnWord[BTN_W-1:0]   = i_io_btn;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < N_HEX; k++) begin
                if ((hexWordBase + 32'(j)) == 32'(k)) hexWord[8*j +: 8] = hex_q[k];
            end
        end
        case (region)
            RG_LEDR: ioWord = ledrWord;
            RG_LEDG: ioWord = ledgWord;
            RG_LCD:  ioWord = lcd_q;
            RG_HEX:  ioWord = hexWord;
            RG_SW:   ioWord = swWord;
            RG_BTN:  ioWord = btnWord;
            default: ioWord = '0;
        endcase
    end

    // Response state sampled at the end of ACCESS, lining up with the
    // registered DMEM read data that appears in RESP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fault_q  <= 1'b0;
            ioWord_q <= '0;
            isDmem_q <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            fault_q  <= fault;
            ioWord_q <= ioWord;
            isDmem_q <= (region == RG_DMEM);
        end
    end

    // Digit k shows the low seven bits of HEX byte k.
    always_comb begin
        o_io_hex = '0;
        for (int k = 0; k < N_HEX; k++) o_io_hex[7*k +: 7] = hex_q[k][6:0];
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// ---------------------------------------------------------------------------
// tb_lsu_mmio
// Directed and randomized transactions against lsu_mmio, compared with a
// byte-oriented reference model of memory and I/O kept in this bench.
// ---------------------------------------------------------------------------
module tb_lsu_mmio;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        o_ready;
    logic        i_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        o_rsp_valid;
    logic [31:0] o_ld_data;
    logic        o_fault;
    logic [17:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic [16:0] o_io_ledr;
    logic [7:0]  o_io_ledg;
    logic [55:0] o_io_hex;
    logic [31:0] o_io_lcd;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0]  memM [int];
    logic [16:0] ledrM;
    logic [7:0]  ledgM;
    logic [31:0] lcdM;
    logic [7:0]  hexM [8];

    lsu_mmio dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .o_ready     (o_ready),
        .i_wren      (i_wren),
        .i_funct3    (i_funct3),
        .i_lsu_addr  (i_lsu_addr),
        .i_st_data   (i_st_data),
        .o_rsp_valid (o_rsp_valid),
        .o_ld_data   (o_ld_data),
        .o_fault     (o_fault),
        .i_io_sw     (i_io_sw),
        .i_io_btn    (i_io_btn),
        .o_io_ledr   (o_io_ledr),
        .o_io_ledg   (o_io_ledg),
        .o_io_hex    (o_io_hex),
        .o_io_lcd    (o_io_lcd)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 unmapped, 1 DMEM, 2 LEDR, 3 LEDG, 4 HEX, 5 LCD, 6 SW, 7 BTN
    function automatic int regionOf(input logic [31:0] a);
        if (a >= 32'h2000 && a < 32'h2000 + 32'd8192) return 1;
        if (a >= 32'h7000 && a <= 32'h700F) return 2;
        if (a >= 32'h7010 && a <= 32'h701F) return 3;
        if (a >= 32'h7020 && a <= 32'h7027) return 4;
        if (a >= 32'h7030 && a <= 32'h703F) return 5;
        if (a >= 32'h7800 && a <= 32'h780F) return 6;
        if (a >= 32'h7810 && a <= 32'h781F) return 7;
        return 0;
    endfunction

    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic modelFault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int r  = regionOf(a);
        int sz = sizeOf(f3);
        if (sz == 0 || (wr && f3 > 3'd2)) return 1'b1;
        if (r == 0) return 1'b1;
        if (sz == 2 && a % 2 != 0) return 1'b1;
        if (sz == 4 && a % 4 != 0) return 1'b1;
        if (wr && r >= 6) return 1'b1;
        if (wr && (r == 2 || r == 3 || r == 5) && f3 != 3'd2) return 1'b1;
        if (r == 4 && a + 32'(sz) - 1 > 32'h7027) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] byteAt(input logic [31:0] a);
        logic [31:0] word;
        int sh = 8 * int'(a % 4);
        case (regionOf(a))
            1: return memM[int'(a - 32'h2000)];
            2: word = {15'b0, ledrM};
            3: word = {24'b0, ledgM};
            4: return hexM[int'(a - 32'h7020)];
            5: word = lcdM;
            6: word = {14'b0, i_io_sw};
            7: word = {28'b0, i_io_btn};
            default: word = 32'b0;
        endcase
        return 8'((word >> sh) & 32'hFF);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 0;
        int sz = sizeOf(f3);
        for (int i = 0; i < sz; i++) v = v | ({24'b0, byteAt(a + 32'(i))} << (8 * i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic modelStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz = sizeOf(f3);
        case (regionOf(a))
            1: for (int i = 0; i < sz; i++) memM[int'(a - 32'h2000) + i] = 8'(d >> (8 * i));
            2: ledrM = d[16:0];
            3: ledgM = d[7:0];
            4: for (int i = 0; i < sz; i++) hexM[int'(a - 32'h7020) + i] = 8'(d >> (8 * i));
            5: lcdM = d;
            default: ;
        endcase
    endtask

    task automatic modelReset();
        ledrM = 0;
        ledgM = 0;
        lcdM  = 0;
        for (int k = 0; k < 8; k++) hexM[k] = 8'h00;
    endtask

    task automatic checkIo(input string tag);
        logic [55:0] expHex = 0;
        for (int k = 0; k < 8; k++) expHex[7*k +: 7] = hexM[k][6:0];
        checkOutput({tag, "_ledr"}, {47'b0, o_io_ledr}, {47'b0, ledrM});
        checkOutput({tag, "_ledg"}, {56'b0, o_io_ledg}, {56'b0, ledgM});
        checkOutput({tag, "_lcd"},  {32'b0, o_io_lcd},  {32'b0, lcdM});
        checkOutput({tag, "_hex"},  {8'b0, o_io_hex},   {8'b0, expHex});
    endtask

    // One transaction with the fixed accept / +1 / +2 timing checked on the way.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] ld, output logic flt);
        @(negedge i_clk);
        checkOutput("ready_idle", {63'b0, o_ready}, 64'd1);
        i_req = 1'b1; i_wren = wr; i_funct3 = f3; i_lsu_addr = a; i_st_data = d;
        @(negedge i_clk);
        i_req = 1'b0;
        checkOutput("ready_busy", {63'b0, o_ready}, 64'd0);
        checkOutput("rsp_early", {63'b0, o_rsp_valid}, 64'd0);
        @(negedge i_clk);
        checkOutput("rsp_at_accept_plus2", {63'b0, o_rsp_valid}, 64'd1);
        ld  = o_ld_data;
        flt = o_fault;
    endtask

    task automatic runOp(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] ld);
        logic        expF = modelFault(wr, f3, a);
        logic [31:0] expL = (wr || expF) ? 32'b0 : modelLoad(f3, a);
        logic        flt;
        applyStimulus(wr, f3, a, d, ld, flt);
        checkOutput($sformatf("fault_%0s_f3%0d_%h", wr ? "st" : "ld", f3, a), {63'b0, flt}, {63'b0, expF});
        checkOutput($sformatf("lddata_%0s_f3%0d_%h", wr ? "st" : "ld", f3, a), {32'b0, ld}, {32'b0, expL});
        if (wr && !expF) modelStore(f3, a, d);
        checkIo("io");
    endtask

    logic [31:0] ld;
    logic [31:0] unmapped [5];

    initial begin
        unmapped = '{32'h6000, 32'h1FFC, 32'h4000, 32'h7040, 32'h7820};
        i_rst = 1'b1; i_req = 1'b0; i_wren = 1'b0; i_funct3 = 3'b0;
        i_lsu_addr = 0; i_st_data = 0; i_io_sw = 0; i_io_btn = 0;
        modelReset();
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checkOutput("reset_ready", {63'b0, o_ready}, 64'd1);
        checkOutput("reset_rsp", {63'b0, o_rsp_valid}, 64'd0);
        checkOutput("reset_fault", {63'b0, o_fault}, 64'd0);
        checkOutput("reset_lddata", {32'b0, o_ld_data}, 64'd0);
        checkIo("reset");

        // Give the model a known DMEM window before random traffic.
        for (int w = 0; w < 16; w++) runOp(1'b1, 3'd2, 32'h2000 + 32'(4 * w), $urandom, ld);

        runOp(1'b1, 3'd2, 32'h2000, 32'hDEADBEEF, ld);
        runOp(1'b0, 3'd2, 32'h2000, 0, ld);
        checkOutput("lw_deadbeef", {32'b0, ld}, 64'hDEADBEEF);
        runOp(1'b1, 3'd0, 32'h2001, 32'h55, ld);
        runOp(1'b0, 3'd0, 32'h2001, 0, ld);
        checkOutput("lb_2001", {32'b0, ld}, 64'h00000055);
        runOp(1'b0, 3'd1, 32'h2002, 0, ld);
        checkOutput("lh_2002", {32'b0, ld}, 64'hFFFFDEAD);
        runOp(1'b0, 3'd5, 32'h2002, 0, ld);
        checkOutput("lhu_2002", {32'b0, ld}, 64'h0000DEAD);
        runOp(1'b0, 3'd2, 32'h2000, 0, ld);
        checkOutput("lw_after_sb", {32'b0, ld}, 64'hDEAD55EF);

        runOp(1'b0, 3'd2, 32'h2002, 0, ld);
        runOp(1'b1, 3'd1, 32'h2003, 32'h1234, ld);
        runOp(1'b0, 3'd2, 32'h6000, 0, ld);
        runOp(1'b1, 3'd2, 32'h7800, 32'hFFFF, ld);
        runOp(1'b0, 3'd2, 32'h2000, 0, ld);
        checkOutput("lw_unchanged", {32'b0, ld}, 64'hDEAD55EF);

        runOp(1'b1, 3'd2, 32'h7020, 32'h7F3F0679, ld);
        checkOutput("hex0", {57'b0, o_io_hex[6:0]}, 64'h79);
        checkOutput("hex1", {57'b0, o_io_hex[13:7]}, 64'h06);
        checkOutput("hex2", {57'b0, o_io_hex[20:14]}, 64'h3F);
        checkOutput("hex3", {57'b0, o_io_hex[27:21]}, 64'h7F);
        runOp(1'b0, 3'd4, 32'h7022, 0, ld);
        checkOutput("lbu_7022", {32'b0, ld}, 64'h3F);

        // DMEM top boundary and the first address beyond it.
        runOp(1'b1, 3'd2, 32'h3FFC, 32'hA5A5_0F0F, ld);
        runOp(1'b0, 3'd2, 32'h3FFC, 0, ld);
        checkOutput("lw_top", {32'b0, ld}, 64'hA5A50F0F);
        runOp(1'b0, 3'd2, 32'h4000, 0, ld);
        runOp(1'b1, 3'd2, 32'h7000, 32'hFFFF_FFFF, ld);
        runOp(1'b0, 3'd2, 32'h7000, 0, ld);
        checkOutput("ledr_zext", {32'b0, ld}, 64'h0001FFFF);
        runOp(1'b1, 3'd0, 32'h7010, 32'hFF, ld);

        i_io_sw = 18'h2ABCD;
        runOp(1'b0, 3'd2, 32'h7800, 0, ld);
        checkOutput("lw_sw", {32'b0, ld}, 64'h0002ABCD);

        // Back-to-back requests: one accept every third cycle.
        @(negedge i_clk);
        i_req = 1'b1; i_wren = 1'b0; i_funct3 = 3'd2; i_lsu_addr = 32'h7800; i_st_data = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            checkOutput($sformatf("stream_ready_c%0d", c), {63'b0, o_ready}, (c % 3 == 0) ? 64'd1 : 64'd0);
            checkOutput($sformatf("stream_rsp_c%0d", c), {63'b0, o_rsp_valid}, (c % 3 == 2) ? 64'd1 : 64'd0);
            if (c % 3 == 2) checkOutput("stream_ld", {32'b0, o_ld_data}, 64'h0002ABCD);
            @(negedge i_clk);
        end
        i_req = 1'b0;

        // Reset during the ACCESS cycle of an LEDR store.
        runOp(1'b1, 3'd2, 32'h7000, 32'h123, ld);
        @(negedge i_clk);
        i_req = 1'b1; i_wren = 1'b1; i_funct3 = 3'd2; i_lsu_addr = 32'h7000; i_st_data = 32'h1FFFF;
        @(negedge i_clk);
        i_req = 1'b0;
        i_rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_mid_rsp", {63'b0, o_rsp_valid}, 64'd0);
        checkOutput("rst_mid_ledr", {47'b0, o_io_ledr}, 64'd0);
        @(negedge i_clk);
        checkOutput("rst_hold_rsp", {63'b0, o_rsp_valid}, 64'd0);
        i_rst = 1'b0;
        #1;
        checkOutput("rst_rel_ready", {63'b0, o_ready}, 64'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            checkOutput("rst_after_rsp", {63'b0, o_rsp_valid}, 64'd0);
            checkOutput("rst_after_ledr", {47'b0, o_io_ledr}, 64'd0);
        end
        checkIo("rst_after");

        // Randomized traffic over every region.
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic        wr = 1'($urandom_range(0, 1));
            logic [31:0] a;
            int          sz = sizeOf(f3);
            i_io_sw  = 18'($urandom);
            i_io_btn = 4'($urandom);
            case ($urandom_range(0, 7))
                0:       a = 32'h2000 + 32'($urandom_range(0, 63));
                1:       a = 32'h7000 + 32'($urandom_range(0, 15));
                2:       a = 32'h7010 + 32'($urandom_range(0, 15));
                3:       a = 32'h7020 + 32'($urandom_range(0, 7));
                4:       a = 32'h7030 + 32'($urandom_range(0, 15));
                5:       a = 32'h7800 + 32'($urandom_range(0, 15));
                6:       a = 32'h7810 + 32'($urandom_range(0, 15));
                default: a = unmapped[$urandom_range(0, 4)];
            endcase
            if (sz > 1 && $urandom_range(0, 2) != 0) a = a & ~32'(sz - 1);
            runOp(wr, f3, a, $urandom, ld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
